// File: rtl/eth_ctl.sv
// Ethernet PHY management controller: PHY reset/interrupt control, clause-22 MDIO master
// and block/error event counters behind a four-register Wishbone slave.
`timescale 1ns/1ps
module eth_ctl #(
    parameter int unsigned CLKDIV = 25
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [1:0]  wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack,
    inout  wire         phymdio,
    output logic        phymdc,
    input  logic        phyint,
    output logic        phyrst,
    input  logic        blkcnt,
    input  logic        errcnt
);
    localparam int unsigned DivW = $clog2(CLKDIV);

    typedef enum logic [2:0] {StIdle, StPre, StHdr, StTa, StData} state_e;

    state_e            state_q, state_d;
    logic              ack_q, ack_seen_q;
    logic [31:0]       dat_q, rdata;
    logic              run_q, int_meta_q, int_sync_q;
    logic [31:0]       blk_q, err_q;
    logic [10:0]       cmd_q;
    logic [15:0]       wdata_q, data_q, rd_sr_q;
    logic [5:0]        bit_q;
    logic [DivW-1:0]   div_q;
    logic              mdc_q;
    logic              req, acc, wr, busy, start, tick, rise, fall;
    logic [63:0]       frame;
    logic              mdio_oe, mdio_out;
    logic              unused_dat;

    assign unused_dat = ^wb_dat_i[30:27];

    // One access per strobe: ack_seen_q blocks a second ack until the strobe drops.
    assign req   = wb_cyc & wb_stb;
    assign acc   = req & ~ack_q & ~ack_seen_q;
    assign wr    = acc & wb_we;
    assign busy  = (state_q != StIdle);
    assign start = wr & (wb_adr == 2'd1) & ~busy;
    assign tick  = busy & (div_q == DivW'(CLKDIV - 1));
    assign rise  = tick & ~mdc_q;
    assign fall  = tick & mdc_q;

    always_comb begin
        rdata = 32'h0;
        case (wb_adr)
            2'd0: rdata = {run_q, 29'h0, busy, int_sync_q};
            2'd1: rdata = {busy, 4'h0, cmd_q, data_q};
            2'd2: rdata = blk_q;
            2'd3: rdata = err_q;
            default: rdata = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            ack_q      <= 1'b0;
            ack_seen_q <= 1'b0;
            dat_q      <= 32'h0;
            run_q      <= 1'b0;
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
            blk_q      <= 32'h0;
            err_q      <= 32'h0;
        end else begin
            ack_q      <= acc;
            ack_seen_q <= req & (ack_seen_q | ack_q);
            if (acc) dat_q <= rdata;
            if (wr && wb_adr == 2'd0) run_q <= wb_dat_i[31];
            int_meta_q <= phyint;
            int_sync_q <= int_meta_q;
            blk_q <= (wr && wb_adr == 2'd2) ? 32'h0 : blk_q + 32'(blkcnt);
            err_q <= (wr && wb_adr == 2'd3) ? 32'h0 : err_q + 32'(errcnt);
        end
    end

    // FSM state register
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // FSM next state: each phase ends on the falling MDC edge closing its last bit
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start)                 state_d = StPre;
            StPre:  if (fall && bit_q == 6'd31) state_d = StHdr;
            StHdr:  if (fall && bit_q == 6'd45) state_d = StTa;
            StTa:   if (fall && bit_q == 6'd47) state_d = StData;
            StData: if (fall && bit_q == 6'd63) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            cmd_q   <= 11'h0;
            wdata_q <= 16'h0;
            data_q  <= 16'h0;
            rd_sr_q <= 16'h0;
            bit_q   <= 6'd0;
            div_q   <= '0;
            mdc_q   <= 1'b0;
        end else if (start) begin
            cmd_q   <= wb_dat_i[26:16];
            wdata_q <= wb_dat_i[15:0];
            bit_q   <= 6'd0;
            div_q   <= '0;
            mdc_q   <= 1'b0;
        end else if (busy) begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) mdc_q <= ~mdc_q;
            if (fall) bit_q <= bit_q + 6'd1;
            if (rise && state_q == StData && !cmd_q[10]) rd_sr_q <= {rd_sr_q[14:0], phymdio};
            if (fall && state_q == StData && bit_q == 6'd63)
                data_q <= cmd_q[10] ? wdata_q : rd_sr_q;
        end
    end

    // FSM outputs: the line is owned for the whole write frame, but only up to TA on a read
    always_comb begin
        frame    = {32'hFFFF_FFFF, 2'b01, (cmd_q[10] ? 2'b01 : 2'b10), cmd_q[9:0], 2'b10, wdata_q};
        mdio_out = frame[6'd63 - bit_q];
        mdio_oe  = 1'b0;
        unique case (state_q)
            StIdle:        mdio_oe = 1'b0;
            StPre, StHdr:  mdio_oe = 1'b1;
            StTa, StData:  mdio_oe = cmd_q[10];
            default:       mdio_oe = 1'b0;
        endcase
    end

    assign phymdio  = mdio_oe ? mdio_out : 1'bz;
    assign phymdc   = mdc_q;
    assign phyrst   = run_q;
    assign wb_ack   = ack_q;
    assign wb_dat_o = dat_q;
endmodule

// File: tb/tb_eth_ctl.sv
// Scoreboard bench for eth_ctl: Wishbone read data and the MDIO bit stream are checked by
// monitors against queues filled when stimulus is issued.
`timescale 1ns/1ps
module tb_eth_ctl;
    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [1:0]  wb_adr = 2'd0;
    logic [31:0] wb_dat_i = 32'h0;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    wire         phymdio;
    logic        phymdc, phyrst;
    logic        phyint = 1'b0, blkcnt = 1'b0, errcnt = 1'b0;

    // PHY model drive and a test probe that pulls the line low to detect a driver
    logic        phy_oe = 1'b0, phy_val = 1'b0, probe_oe = 1'b0;
    logic        phy_read = 1'b0;
    logic [15:0] phy_data = 16'h0;
    int          mdc_bits = 0;

    int tests = 0, fails = 0, ack_cnt = 0;
    logic [31:0] exp_rd[$];
    string       exp_name[$];
    logic        exp_bits[$];

    assign phymdio = probe_oe ? 1'b0 : (phy_oe ? phy_val : 1'bz);

    eth_ctl #(.CLKDIV(25)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
        .phymdio(phymdio), .phymdc(phymdc), .phyint(phyint), .phyrst(phyrst),
        .blkcnt(blkcnt), .errcnt(errcnt)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Wishbone monitor
    always begin
        @(negedge wb_clk);
        if (wb_ack) begin
            ack_cnt++;
            if (!wb_we) begin
                if (exp_rd.size() == 0) check("unexpected_read_ack", 32'd1, 32'd0);
                else check(exp_name.pop_front(), wb_dat_o, exp_rd.pop_front());
            end
        end
    end

    // MDIO monitor: one expected bit per MDC rising edge
    always begin
        @(posedge phymdc);
        #2;
        mdc_bits++;
        if (exp_bits.size() == 0) check("mdc_unexpected_edge", 32'd1, 32'd0);
        else check($sformatf("mdio_bit%0d", mdc_bits - 1), {31'h0, phymdio},
                   {31'h0, exp_bits.pop_front()});
    end

    // PHY model: drives TA low and the read data after each MDC falling edge
    always begin
        @(negedge phymdc);
        #1;
        if (phy_read && mdc_bits >= 46 && mdc_bits <= 63) begin
            phy_oe  = 1'b1;
            phy_val = (mdc_bits < 48) ? 1'b0 : phy_data[63 - mdc_bits];
        end else begin
            phy_oe = 1'b0;
        end
    end

    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat);
        logic got;
        @(posedge wb_clk);
        #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge wb_clk);
            #1;
            if (wb_ack) got = 1'b1;
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(negedge wb_clk);
        #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_rd(input logic [1:0] adr, input logic [31:0] exp, input string name);
        exp_rd.push_back(exp);
        exp_name.push_back(name);
        wb_xfer(1'b0, adr, 32'h0);
    endtask

    // Expected 64-bit MDC stream; on reads the TA and data bits are what the PHY model drives
    task automatic push_frame(input logic op, input logic [4:0] pa, input logic [4:0] ra,
                              input logic [15:0] data);
        logic [63:0] f;
        f = {32'hFFFF_FFFF, 2'b01, (op ? 2'b01 : 2'b10), pa, ra, (op ? 2'b10 : 2'b00), data};
        for (int i = 63; i >= 0; i--) exp_bits.push_back(f[i]);
        phy_read = !op;
        phy_data = data;
        mdc_bits = 0;
    endtask

    initial begin
        // reset values
        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_phyrst", {31'h0, phyrst}, 32'd0);
        check("rst_phymdc", {31'h0, phymdc}, 32'd0);
        check("rst_ack", {31'h0, wb_ack}, 32'd0);
        check("rst_dat_o", wb_dat_o, 32'h0);
        probe_oe = 1'b1;
        #1;
        check("rst_mdio_released", {31'h0, phymdio}, 32'd0);
        probe_oe = 1'b0;
        wb_rst = 1'b1;
        for (int a = 0; a < 4; a++) wb_rd(2'(a), 32'h0, $sformatf("rst_read_adr%0d", a));

        // CTRL write with held strobes: exactly one ack each
        for (int k = 0; k < 2; k++) begin
            int n0;
            n0 = ack_cnt;
            @(posedge wb_clk);
            #1;
            wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 2'd0; wb_dat_i = 32'h8000_0000;
            repeat (k == 0 ? 2 : 4) @(posedge wb_clk);
            #1;
            wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
            repeat (3) @(posedge wb_clk);
            #1;
            check($sformatf("held_strobe_ack_pulses_%0d", k), 32'(ack_cnt - n0), 32'd1);
        end
        check("phyrst_released", {31'h0, phyrst}, 32'd1);
        wb_rd(2'd0, 32'h8000_0000, "ctrl_run");

        // read frame: PHY 2, reg 2, PHY returns 0x0141
        push_frame(1'b0, 5'd2, 5'd2, 16'h0141);
        wb_xfer(1'b1, 2'd1, 32'h0042_0000);
        repeat (3190) @(posedge wb_clk);
        wb_rd(2'd0, 32'h8000_0002, "rd_frame_busy");
        repeat (10) @(posedge wb_clk);
        wb_rd(2'd0, 32'h8000_0000, "rd_frame_done");
        wb_rd(2'd1, 32'h0042_0141, "rd_frame_result");
        check("rd_frame_bits_left", 32'(exp_bits.size()), 32'd0);

        // write frame: PHY 5, reg 3, data 0xBEEF; second command mid-frame is dropped
        push_frame(1'b1, 5'd5, 5'd3, 16'hBEEF);
        wb_xfer(1'b1, 2'd1, 32'h04A3_BEEF);
        repeat (1000) @(posedge wb_clk);
        wb_xfer(1'b1, 2'd1, 32'h0042_0000);
        repeat (2188) @(posedge wb_clk);
        wb_rd(2'd0, 32'h8000_0002, "wr_frame_busy");
        repeat (10) @(posedge wb_clk);
        wb_rd(2'd1, 32'h04A3_BEEF, "wr_frame_result");
        check("wr_frame_bits_left", 32'(exp_bits.size()), 32'd0);

        // counters
        @(posedge wb_clk);
        #1;
        blkcnt = 1'b1; errcnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge wb_clk);
            #1;
            if (i == 2) errcnt = 1'b0;
        end
        blkcnt = 1'b0;
        wb_rd(2'd2, 32'd5, "blkcnt_5");
        wb_rd(2'd3, 32'd3, "errcnt_3");
        blkcnt = 1'b1;
        wb_xfer(1'b1, 2'd2, 32'h0);
        blkcnt = 1'b0;
        wb_rd(2'd2, 32'd0, "blkcnt_clear_beats_inc");
        wb_rd(2'd3, 32'd3, "errcnt_untouched");

        // phyint synchroniser
        phyint = 1'b1;
        repeat (3) @(posedge wb_clk);
        wb_rd(2'd0, 32'h8000_0001, "phyint_high");
        phyint = 1'b0;
        repeat (3) @(posedge wb_clk);
        wb_rd(2'd0, 32'h8000_0000, "phyint_low");

        // reset mid-frame
        push_frame(1'b1, 5'd1, 5'd1, 16'h1234);
        wb_xfer(1'b1, 2'd1, 32'h0421_1234);
        repeat (500) @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;
        #1;
        exp_bits.delete();
        check("abort_phymdc", {31'h0, phymdc}, 32'd0);
        check("abort_phyrst", {31'h0, phyrst}, 32'd0);
        probe_oe = 1'b1;
        #1;
        check("abort_mdio_released", {31'h0, phymdio}, 32'd0);
        probe_oe = 1'b0;
        repeat (2) @(posedge wb_clk);
        #1;
        wb_rst = 1'b1;
        wb_rd(2'd0, 32'h0, "abort_ctrl_idle");
        wb_rd(2'd1, 32'h0, "abort_mdio_reg");
        wb_rd(2'd3, 32'h0, "abort_errcnt");

        repeat (5) @(posedge wb_clk);
        check("reads_outstanding", 32'(exp_rd.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
